// File: rtl/bsg_mux_one_hot_pipelined.sv
// bsg_mux_one_hot_pipelined
// Registered one-hot multiplexer with valid/ready handshakes on both sides.
// The selected word passes through a two-entry buffer (main + skid register),
// so ready_o comes straight from a flop and a word can still be accepted in
// every cycle.
// Optional one-hot checker: define BSG_MUX_ONE_HOT_PIPELINED_CHECK_EN to get
// a sticky err_o and a saturating err_cnt_o. Without the macro, both are tied to 0.
module bsg_mux_one_hot_pipelined #(
   parameter int width_p         = 4,
   parameter int els_p           = 2,
   parameter int err_cnt_width_p = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic [els_p*width_p-1:0]   data_i,
   input  logic [els_p-1:0]           sel_one_hot_i,
   input  logic                       v_i,
   output logic                       ready_o,
   output logic [width_p-1:0]         data_o,
   output logic                       v_o,
   input  logic                       ready_i,
   output logic                       err_o,
   output logic [err_cnt_width_p-1:0] err_cnt_o
);

   logic               main_v, skid_v;
   logic [width_p-1:0] main_data, skid_data;
   logic [width_p-1:0] mux_data;
   logic               in_xfer, out_xfer;

   // AND-OR mux: every selected word is ORed in, with no priority
   always_comb begin
      mux_data = '0;
      for (int unsigned k = 0; k < els_p; k++) begin
         mux_data = mux_data | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
      end
   end

   assign in_xfer  = v_i & ~skid_v;
   assign out_xfer = main_v & ready_i;

   // occupancy update: EMPTY -> ONE -> TWO, with main always holding the oldest word
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         main_v    <= 1'b0;
         skid_v    <= 1'b0;
         main_data <= '0;
         skid_data <= '0;
      end else if (!main_v) begin
         if (in_xfer) begin
            main_v    <= 1'b1;
            main_data <= mux_data;
         end
      end else if (!skid_v) begin
         if (in_xfer && out_xfer) begin
            main_data <= mux_data;
         end else if (in_xfer) begin
            skid_v    <= 1'b1;
            skid_data <= mux_data;
         end else if (out_xfer) begin
            main_v <= 1'b0;
         end
      end else if (out_xfer) begin
         main_data <= skid_data;
         skid_v    <= 1'b0;
      end
   end

   assign ready_o = ~skid_v;
   assign v_o     = main_v;
   assign data_o  = main_data;

   // a skid entry without a main entry would break FIFO ordering
   skid_without_main : assert property (@(posedge clk_i) disable iff (!reset_n_i) (main_v || !skid_v));

`ifdef BSG_MUX_ONE_HOT_PIPELINED_CHECK_EN
   logic                       sel_seen, sel_multi, sel_bad;
   logic                       err_r;
   logic [err_cnt_width_p-1:0] err_cnt_r;

   // a select is legal only when exactly one bit is set
   always_comb begin
      sel_seen  = 1'b0;
      sel_multi = 1'b0;
      for (int unsigned k = 0; k < els_p; k++) begin
         if (sel_one_hot_i[k]) begin
            if (sel_seen) sel_multi = 1'b1;
            sel_seen = 1'b1;
         end
      end
      sel_bad = ~sel_seen | sel_multi;
   end

   // sticky error flag and saturating counter, updated only by accepted words
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_r     <= 1'b0;
         err_cnt_r <= '0;
      end else if (in_xfer && sel_bad) begin
         err_r <= 1'b1;
         if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + 1'b1;
      end
   end

   assign err_o     = err_r;
   assign err_cnt_o = err_cnt_r;
`else
   assign err_o     = 1'b0;
   assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mux_one_hot_pipelined.sv
// Directed bench for bsg_mux_one_hot_pipelined. It covers the default
// configuration (4x2) and a wide configuration (32x7) with a scoreboard.
module tb_bsg_mux_one_hot_pipelined;

`ifdef BSG_MUX_ONE_HOT_PIPELINED_CHECK_EN
   localparam bit chk_en = 1'b1;
`else
   localparam bit chk_en = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] data;
   logic [1:0] sel;
   logic       v, ready_in;
   logic       ready_out, v_out, err;
   logic [3:0] data_out;
   logic [7:0] err_cnt;

   logic [223:0] w_data;
   logic [6:0]   w_sel;
   logic         w_v, w_ready_in;
   logic         w_ready_out, w_v_out, w_err;
   logic [31:0]  w_data_out;
   logic [7:0]   w_err_cnt;

   int total = 0;
   int bad   = 0;
   logic [31:0] q[$];
   int idx;
   int n_in = 0;

   always #5 clk = ~clk;

   bsg_mux_one_hot_pipelined #(.width_p(4), .els_p(2), .err_cnt_width_p(8)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .data_i(data), .sel_one_hot_i(sel), .v_i(v),
      .ready_o(ready_out), .data_o(data_out), .v_o(v_out), .ready_i(ready_in),
      .err_o(err), .err_cnt_o(err_cnt));

   bsg_mux_one_hot_pipelined #(.width_p(32), .els_p(7), .err_cnt_width_p(8)) u_wide (
      .clk_i(clk), .reset_n_i(reset_n), .data_i(w_data), .sel_one_hot_i(w_sel), .v_i(w_v),
      .ready_o(w_ready_out), .data_o(w_data_out), .v_o(w_v_out), .ready_i(w_ready_in),
      .err_o(w_err), .err_cnt_o(w_err_cnt));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // check the wide DUT's handshakes before the next edge, then advance
   task automatic wide_step();
      if (w_v_out && w_ready_in) begin
         if (q.size() == 0) chk("wide_unexpected_v", {63'd0, w_v_out}, 64'd0);
         else chk("wide_data", {32'd0, w_data_out}, {32'd0, q.pop_front()});
      end
      if (w_v && w_ready_out) begin
         q.push_back(w_data[idx*32 +: 32]);
         n_in++;
      end
      cyc();
   endtask

   initial begin
      data = '0; sel = '0; v = 1'b0; ready_in = 1'b1;
      w_data = '0; w_sel = '0; w_v = 1'b0; w_ready_in = 1'b1; idx = 0;

      // reset values while reset is held
      #2;
      chk("rst_v_o", {63'd0, v_out}, 64'd0);
      chk("rst_data_o", {60'd0, data_out}, 64'd0);
      chk("rst_ready_o", {63'd0, ready_out}, 64'd1);
      chk("rst_err_o", {63'd0, err}, 64'd0);
      chk("rst_err_cnt_o", {56'd0, err_cnt}, 64'd0);
      #10 reset_n = 1'b1;

      // basic select
      v = 1'b1; data = 8'hA5; sel = 2'b01;
      cyc();
      chk("sel0_v", {63'd0, v_out}, 64'd1);
      chk("sel0_data", {60'd0, data_out}, 64'h5);
      sel = 2'b10;
      cyc();
      chk("sel1_data", {60'd0, data_out}, 64'hA);
      v = 1'b0;
      cyc();
      chk("sel_idle_v", {63'd0, v_out}, 64'd0);

      // back-pressure through the skid register; word 3 waits while full
      ready_in = 1'b0; v = 1'b1; sel = 2'b01; data = 8'h01;
      cyc();
      chk("bp_w1_data", {60'd0, data_out}, 64'h1);
      chk("bp_w1_ready", {63'd0, ready_out}, 64'd1);
      data = 8'h02;
      cyc();
      chk("bp_full_ready", {63'd0, ready_out}, 64'd0);
      chk("bp_full_data", {60'd0, data_out}, 64'h1);
      data = 8'h03;
      cyc();
      chk("bp_hold_data", {60'd0, data_out}, 64'h1);
      chk("bp_hold_ready", {63'd0, ready_out}, 64'd0);
      ready_in = 1'b1;
      cyc();
      chk("bp_drain_w2", {60'd0, data_out}, 64'h2);
      chk("bp_drain_ready", {63'd0, ready_out}, 64'd1);
      cyc();
      chk("bp_w3", {60'd0, data_out}, 64'h3);
      chk("bp_w3_v", {63'd0, v_out}, 64'd1);
      v = 1'b0;
      cyc();
      chk("bp_empty_v", {63'd0, v_out}, 64'd0);

      // streaming at full rate
      v = 1'b1; sel = 2'b01;
      for (int i = 0; i < 16; i++) begin
         data = {4'h0, 4'(i)};
         cyc();
         chk("stream_data", {60'd0, data_out}, 64'(i));
         chk("stream_v", {63'd0, v_out}, 64'd1);
         chk("stream_ready", {63'd0, ready_out}, 64'd1);
      end
      v = 1'b0;
      cyc();

      // non-one-hot selects
      v = 1'b1; sel = 2'b11; data = 8'h3C;
      cyc();
      chk("multi_data", {60'd0, data_out}, 64'hF);
      chk("multi_err", {63'd0, err}, {63'd0, chk_en});
      chk("multi_cnt", {56'd0, err_cnt}, chk_en ? 64'd1 : 64'd0);
      sel = 2'b00;
      cyc();
      chk("zero_data", {60'd0, data_out}, 64'h0);
      chk("zero_v", {63'd0, v_out}, 64'd1);
      chk("zero_cnt", {56'd0, err_cnt}, chk_en ? 64'd2 : 64'd0);
      sel = 2'b10;
      cyc();
      chk("legal_cnt", {56'd0, err_cnt}, chk_en ? 64'd2 : 64'd0);
      sel = 2'b11;
      for (int i = 0; i < 298; i++) cyc();
      chk("sat_cnt", {56'd0, err_cnt}, chk_en ? 64'hFF : 64'd0);
      chk("sat_err", {63'd0, err}, {63'd0, chk_en});
      v = 1'b0;
      cyc();

      // asynchronous reset while the buffer is full
      ready_in = 1'b0; v = 1'b1; sel = 2'b01; data = 8'h11;
      cyc();
      data = 8'h22;
      cyc();
      chk("prereset_ready", {63'd0, ready_out}, 64'd0);
      v = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_v", {63'd0, v_out}, 64'd0);
      chk("async_rst_ready", {63'd0, ready_out}, 64'd1);
      chk("async_rst_data", {60'd0, data_out}, 64'd0);
      chk("async_rst_cnt", {56'd0, err_cnt}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1; ready_in = 1'b1;
      cyc();
      chk("post_rst_no_stale", {63'd0, v_out}, 64'd0);
      v = 1'b1; sel = 2'b10; data = 8'h50;
      cyc();
      chk("post_rst_v", {63'd0, v_out}, 64'd1);
      chk("post_rst_data", {60'd0, data_out}, 64'h5);
      v = 1'b0;
      cyc();

      // wide configuration: random one-hot selects with random stalls
      for (int c = 0; c < 300; c++) begin
         w_v = ($urandom_range(0, 3) != 0);
         idx = int'($urandom_range(0, 6));
         w_sel = 7'b1 << idx;
         for (int k = 0; k < 7; k++) w_data[k*32 +: 32] = $urandom;
         w_ready_in = ($urandom_range(0, 2) != 0);
         wide_step();
      end
      w_v = 1'b0; w_ready_in = 1'b1;
      for (int c = 0; c < 6; c++) wide_step();
      chk("wide_drained", 64'(q.size()), 64'd0);
      chk("wide_idle_v", {63'd0, w_v_out}, 64'd0);
      chk("wide_traffic", {63'd0, (n_in > 50)}, 64'd1);
      chk("wide_err", {55'd0, w_err, w_err_cnt}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
